axi4_lite_periph_slave: RTL and testbench
=========================================

// Module: axi4_lite_periph_slave
// PURPOSE
//  Parametrised AXI4-lite slave peripheral: WSTRB-aware register file driving LED and seven-segment outputs.
//  Adds a maskable, edge-triggered, multi-source interrupt controller with W1C status.
//  Sits between the AXI4-lite bus interface and the board I/O; one outstanding write and one outstanding read.
// PARAMETERS
//  ADDR_WIDTH   8   byte-address width; ADDR[1:0] ignored (word access only)
//  DATA_WIDTH   32  data width; 32 or 64; WSTRB width = DATA_WIDTH/8
//  LED_W        8   LED_OUT width (<= DATA_WIDTH)
//  SEG_W        8   SEVENSEG_OUT width (<= DATA_WIDTH)
//  NUM_IRQ      4   interrupt sources (1..DATA_WIDTH)
//  NUM_SCRATCH  4   general R/W scratch registers
// PORTS
//  ACLK          in   1             clock; all logic on posedge
//  ARESETn       in   1             synchronous reset, active-low
//  S_AWADDR      in   ADDR_WIDTH    write address
//  S_AWVALID/S_AWREADY  in/out  1   write address handshake
//  S_WDATA       in   DATA_WIDTH    write data
//  S_WSTRB       in   DATA_WIDTH/8  byte strobes
//  S_WVALID/S_WREADY    in/out  1   write data handshake
//  S_BVALID/S_BREADY    out/in  1   write response handshake
//  S_BRESP       out  2             write response
//  S_ARADDR      in   ADDR_WIDTH    read address
//  S_ARVALID/S_ARREADY  in/out  1   read address handshake
//  S_RDATA       out  DATA_WIDTH    read data
//  S_RRESP       out  2             read response
//  S_RVALID/S_RREADY    out/in  1   read data handshake
//  IRQ_IN        in   NUM_IRQ       interrupt event inputs (sync to ACLK)
//  LED_OUT       out  LED_W         LED register value
//  SEVENSEG_OUT  out  SEG_W         seven-segment register value
//  IRQ_OUT       out  1             registered |(STATUS & MASK)
// BEHAVIOUR
//  Reset (ARESETn==0 at posedge): all registers 0; AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; IRQ_OUT=0; IRQ_IN edge history=0.
//  Map (word index = ADDR>>2): 0 LED, 1 SEVENSEG, 2 IRQ_STATUS (W1C), 3 IRQ_MASK, 4..4+NUM_SCRATCH-1 SCRATCH; rest unmapped.
//  Write FSM: W_IDLE -> W_RESP. In W_IDLE, AW and W accepted independently in any order/same cycle; each READY drops
//   after its beat is captured. When both are held, the register is updated on the next edge (byte lanes per WSTRB)
//   and the FSM enters W_RESP. W_RESP: BVALID=1, held until BREADY; then W_IDLE, AWREADY=WREADY=1. Min latency AW+W -> BVALID: 1 cycle.
//  Read FSM: R_IDLE -> R_DATA. AR handshake captures data from current register state into RDATA; RVALID=1 next cycle, held stable until RREADY.
//  Read and write on the same cycle to the same register: read returns old value.
//  Bits above LED_W/SEG_W/NUM_IRQ: write ignored, read 0.
//  IRQ: rising edge on IRQ_IN[i] sets STATUS[i]. Write 1 to STATUS[i] clears it. Same-cycle set and clear: set wins.
//   IRQ_OUT is registered; 1-cycle lag after STATUS/MASK change.
//  Backpressure: BREADY/RREADY low indefinitely -> responses held, no new transaction on that channel.
//   The other channel is unaffected.
//  Reset mid-transaction: outstanding transaction dropped, no response issued, state per reset list.
// CONFIGURATION
//  AXIL_SLVERR_EN defined: unmapped access -> BRESP/RRESP=2'b10 (SLVERR), RDATA=0, no register change.
//  Undefined: unmapped access -> OKAY (2'b00), write discarded, RDATA=0.
// TESTING
//  Reset: ARESETn=0 for 2 cycles -> LED_OUT=0, IRQ_OUT=0, AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0.
//  Write LED 0xA5, WSTRB=4'hF, AW then W 3 cycles later -> BVALID after W, BRESP=0, LED_OUT=8'hA5; read 0x00 -> 0x000000A5.
//  Partial strobe: SCRATCH0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 -> readback 0x11BB33DD.
//  IRQ: MASK=0x1, pulse IRQ_IN[0] -> STATUS=0x1, IRQ_OUT=1; write STATUS=0x1 -> IRQ_OUT=0. IRQ_IN[1] edge with MASK=0x1 -> IRQ_OUT stays 0.
//  Backpressure: RREADY=0 for 10 cycles after read of SEVENSEG=0x3F -> RVALID=1, RDATA=0x3F stable, ARREADY=0; concurrent write completes.
//  Unmapped read 0xFC -> RRESP=2'b10, RDATA=0 with AXIL_SLVERR_EN; RRESP=2'b00 without.

Source files
------------

// File: rtl/axi4_lite_periph_slave.sv
// AXI4-lite peripheral slave: byte-strobed register file for LEDs, seven-segment and scratch words,
// plus an edge-triggered maskable interrupt controller with W1C status. AXIL_SLVERR_EN makes unmapped accesses return SLVERR.
module axi4_lite_periph_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int LED_W       = 8,
    parameter int SEG_W       = 8,
    parameter int NUM_IRQ     = 4,
    parameter int NUM_SCRATCH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [ADDR_WIDTH-1:0]     S_AWADDR,
    input  logic                      S_AWVALID,
    output logic                      S_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
    input  logic                      S_WVALID,
    output logic                      S_WREADY,
    output logic                      S_BVALID,
    input  logic                      S_BREADY,
    output logic [1:0]                S_BRESP,
    input  logic [ADDR_WIDTH-1:0]     S_ARADDR,
    input  logic                      S_ARVALID,
    output logic                      S_ARREADY,
    output logic [DATA_WIDTH-1:0]     S_RDATA,
    output logic [1:0]                S_RRESP,
    output logic                      S_RVALID,
    input  logic                      S_RREADY,
    input  logic [NUM_IRQ-1:0]        IRQ_IN,
    output logic [LED_W-1:0]          LED_OUT,
    output logic [SEG_W-1:0]          SEVENSEG_OUT,
    output logic                      IRQ_OUT
);

    localparam int STRB_W       = DATA_WIDTH / 8;
    localparam int IDX_W        = ADDR_WIDTH - 2;
    localparam int SCRATCH_BASE = 4;
    localparam int NUM_REGS     = SCRATCH_BASE + NUM_SCRATCH;
    localparam int REG_IDX_W    = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [LED_W-1:0]      led_q, led_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_IRQ-1:0]    status_q, status_d;
    logic [NUM_IRQ-1:0]    mask_q, mask_d;
    logic [NUM_IRQ-1:0]    irq_prev_q, irq_prev_d;
    logic                  irq_out_q, irq_out_d;
    logic [DATA_WIDTH-1:0] scratch_q [NUM_SCRATCH];
    logic [DATA_WIDTH-1:0] scratch_d [NUM_SCRATCH];

    logic [DATA_WIDTH-1:0] reg_view [NUM_REGS];
    logic [31:0]           wr_word_idx, rd_word_idx;
    logic [REG_IDX_W-1:0]  wr_sel, rd_sel;
    logic                  wr_mapped, rd_mapped, commit;
    logic [DATA_WIDTH-1:0] merged;
    logic [NUM_IRQ-1:0]    irq_clr, irq_rise;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // Zero-extended view of every mapped register, shared by read mux and write merge.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) reg_view[i] = '0;
        reg_view[0][LED_W-1:0]   = led_q;
        reg_view[1][SEG_W-1:0]   = seg_q;
        reg_view[2][NUM_IRQ-1:0] = status_q;
        reg_view[3][NUM_IRQ-1:0] = mask_q;
        for (int i = 0; i < NUM_SCRATCH; i++) reg_view[SCRATCH_BASE+i] = scratch_q[i];
    end

    assign wr_word_idx = 32'(aw_idx_q);
    assign rd_word_idx = 32'(S_ARADDR[ADDR_WIDTH-1:2]);
    assign wr_sel      = aw_idx_q[REG_IDX_W-1:0];
    assign rd_sel      = S_ARADDR[REG_IDX_W+1:2];
    assign wr_mapped   = wr_word_idx < NUM_REGS;
    assign rd_mapped   = rd_word_idx < NUM_REGS;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        commit    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AWVALID && !aw_held_q) begin
                    aw_held_d = 1'b1;
                    aw_idx_d  = S_AWADDR[ADDR_WIDTH-1:2];
                end
                if (S_WVALID && !w_held_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_WDATA;
                    wstrb_d  = S_WSTRB;
                end
                if (aw_held_q && w_held_q) begin
                    commit    = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (S_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Register updates; a rising IRQ edge in the same cycle as its W1C clear keeps the bit set.
    always_comb begin
        led_d     = led_q;
        seg_d     = seg_q;
        mask_d    = mask_q;
        scratch_d = scratch_q;
        irq_clr   = '0;
        merged    = merge_bytes(reg_view[wr_sel], wdata_q, wstrb_q);
        if (commit && wr_mapped) begin
            case (wr_word_idx)
                32'd0: led_d  = merged[LED_W-1:0];
                32'd1: seg_d  = merged[SEG_W-1:0];
                32'd2: begin
                    for (int i = 0; i < NUM_IRQ; i++) irq_clr[i] = wdata_q[i] & wstrb_q[i/8];
                end
                32'd3: mask_d = merged[NUM_IRQ-1:0];
                default: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (wr_word_idx == 32'(SCRATCH_BASE + i)) scratch_d[i] = merged;
                    end
                end
            endcase
        end
        irq_rise   = IRQ_IN & ~irq_prev_q;
        status_d   = (status_q & ~irq_clr) | irq_rise;
        irq_prev_d = IRQ_IN;
        irq_out_d  = |(status_q & mask_q);
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_ARVALID) begin
                    rdata_d   = rd_mapped ? reg_view[rd_sel] : '0;
                    rresp_d   = rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            led_q      <= '0;
            seg_q      <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            irq_prev_q <= '0;
            irq_out_q  <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            irq_prev_q <= irq_prev_d;
            irq_out_q  <= irq_out_d;
            scratch_q  <= scratch_d;
        end
    end

    assign S_AWREADY    = (w_state_q == W_IDLE) && !aw_held_q;
    assign S_WREADY     = (w_state_q == W_IDLE) && !w_held_q;
    assign S_BVALID     = (w_state_q == W_RESP);
    assign S_BRESP      = bresp_q;
    assign S_ARREADY    = (r_state_q == R_IDLE);
    assign S_RVALID     = (r_state_q == R_DATA);
    assign S_RDATA      = rdata_q;
    assign S_RRESP      = rresp_q;
    assign LED_OUT      = led_q;
    assign SEVENSEG_OUT = seg_q;
    assign IRQ_OUT      = irq_out_q;

endmodule

// File: tb/tb_axi4_lite_periph_slave.sv
// Randomized bench for axi4_lite_periph_slave against a word-level register model.
// Build with +define+AXIL_SLVERR_EN to expect SLVERR on unmapped accesses.
module tb_axi4_lite_periph_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_awaddr, s_araddr;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [3:0]  irq_in;
    logic [7:0]  led_out, seg_out;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    // Reference model: one 32-bit value per mapped word, already masked to its implemented width.
    logic [31:0] m_led, m_seg, m_status, m_mask;
    logic [31:0] m_scr [4];

    axi4_lite_periph_slave dut (
        .ACLK(aclk), .ARESETn(aresetn),
        .S_AWADDR(s_awaddr), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
        .S_BVALID(s_bvalid), .S_BREADY(s_bready), .S_BRESP(s_bresp),
        .S_ARADDR(s_araddr), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .IRQ_IN(irq_in), .LED_OUT(led_out), .SEVENSEG_OUT(seg_out), .IRQ_OUT(irq_out)
    );

    always #5 aclk = ~aclk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_led = 0; m_seg = 0; m_status = 0; m_mask = 0;
        for (int i = 0; i < 4; i++) m_scr[i] = 0;
    endfunction

    function automatic logic is_mapped(input logic [7:0] addr);
        return (addr >> 2) < 8;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        case (addr >> 2)
            0: return m_led;
            1: return m_seg;
            2: return m_status;
            3: return m_mask;
            4, 5, 6, 7: return m_scr[(addr >> 2) - 4];
            default: return 0;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] bm;
        int idx;
        bm = 0;
        for (int b = 0; b < 4; b++) if (strb[b]) bm |= 32'hFF << (8 * b);
        idx = int'(addr >> 2);
        case (idx)
            0: m_led = ((m_led & ~bm) | (data & bm)) & 32'hFF;
            1: m_seg = ((m_seg & ~bm) | (data & bm)) & 32'hFF;
            2: m_status = m_status & ~(data & bm);
            3: m_mask = ((m_mask & ~bm) | (data & bm)) & 32'hF;
            4, 5, 6, 7: m_scr[idx-4] = (m_scr[idx-4] & ~bm) | (data & bm);
            default: ;
        endcase
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge aclk);
        aresetn = 1'b0;
        repeat (cycles) @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs, got;
        int cyc;
        aw_done = 0; w_done = 0; got = 0; cyc = 0; resp = 2'b11;
        while (!(aw_done && w_done) && cyc < 64) begin
            @(negedge aclk);
            s_awaddr  = addr;
            s_wdata   = data;
            s_wstrb   = strb;
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done && (cyc >= w_dly);
            #1;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge aclk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        @(negedge aclk);
        s_awvalid = 0;
        s_wvalid  = 0;
        checkOutput("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
        s_bready = 1;
        for (int i = 0; i < 64 && !got; i++) begin
            #1;
            if (s_bvalid) begin
                resp = s_bresp;
                got  = 1;
            end
            @(posedge aclk);
            @(negedge aclk);
        end
        s_bready = 0;
        checkOutput("bvalid_seen", {31'd0, got}, 32'd1);
        if (got && aw_done && w_done) model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs, got;
        hs = 0; got = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
        @(negedge aclk);
        s_araddr  = addr;
        s_arvalid = 1;
        for (int i = 0; i < 64 && !hs; i++) begin
            #1;
            hs = s_arready;
            @(posedge aclk);
            @(negedge aclk);
        end
        s_arvalid = 0;
        checkOutput("ar_accepted", {31'd0, hs}, 32'd1);
        s_rready = 1;
        for (int i = 0; i < 64 && !got; i++) begin
            #1;
            if (s_rvalid) begin
                data = s_rdata;
                resp = s_rresp;
                got  = 1;
            end
            @(posedge aclk);
            @(negedge aclk);
        end
        s_rready = 0;
        checkOutput("rvalid_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        checkOutput(tag, d, model_read(addr));
        checkOutput("rresp", {30'd0, r}, {30'd0, is_mapped(addr) ? 2'b00 : UNMAP_RESP});
    endtask

    task automatic write_check(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly);
        logic [1:0] r;
        axi_write(addr, data, strb, aw_dly, w_dly, r);
        checkOutput("bresp", {30'd0, r}, {30'd0, is_mapped(addr) ? 2'b00 : UNMAP_RESP});
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        @(negedge aclk);
        irq_in = v;
        @(negedge aclk);
        irq_in = 4'd0;
        m_status |= {28'd0, v};
    endtask

    task automatic check_outputs_settled();
        repeat (2) @(negedge aclk);
        checkOutput("led_out", {24'd0, led_out}, m_led);
        checkOutput("seg_out", {24'd0, seg_out}, m_seg);
        checkOutput("irq_out", {31'd0, irq_out}, {31'd0, |(m_status & m_mask)});
    endtask

    task automatic applyStimulus(input int n);
        logic [7:0] addr;
        for (int k = 0; k < n; k++) begin
            addr = 8'(($urandom_range(0, 11)) << 2) | 8'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1: write_check(addr, $urandom, 4'($urandom_range(0, 15)),
                                  $urandom_range(0, 3), $urandom_range(0, 3));
                2: read_check("rand_read", addr);
                default: pulse_irq(4'($urandom_range(1, 15)));
            endcase
            check_outputs_settled();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        aresetn = 0; s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
        s_bready = 0; s_araddr = 0; s_arvalid = 0; s_rready = 0; irq_in = 0;
        model_reset();

        do_reset(2);
        #1;
        checkOutput("rst_led", {24'd0, led_out}, 32'd0);
        checkOutput("rst_irq_out", {31'd0, irq_out}, 32'd0);
        checkOutput("rst_awready", {31'd0, s_awready}, 32'd1);
        checkOutput("rst_wready", {31'd0, s_wready}, 32'd1);
        checkOutput("rst_arready", {31'd0, s_arready}, 32'd1);
        checkOutput("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
        checkOutput("rst_rvalid", {31'd0, s_rvalid}, 32'd0);

        write_check(8'h00, 32'h0000_00A5, 4'hF, 0, 3);
        checkOutput("led_a5", {24'd0, led_out}, 32'h0000_00A5);
        read_check("led_read", 8'h00);

        write_check(8'h10, 32'h1122_3344, 4'hF, 0, 0);
        write_check(8'h10, 32'hAABB_CCDD, 4'b0101, 2, 0);
        axi_read(8'h10, d, r);
        checkOutput("partial_strb", d, 32'h11BB_33DD);

        write_check(8'h0C, 32'h1, 4'hF, 0, 0);
        pulse_irq(4'b0001);
        check_outputs_settled();
        checkOutput("irq0_raised", {31'd0, irq_out}, 32'd1);
        read_check("status_read", 8'h08);
        write_check(8'h08, 32'h1, 4'hF, 1, 0);
        check_outputs_settled();
        checkOutput("irq0_cleared", {31'd0, irq_out}, 32'd0);
        pulse_irq(4'b0010);
        check_outputs_settled();
        checkOutput("irq1_masked", {31'd0, irq_out}, 32'd0);
        read_check("status_masked", 8'h08);
        write_check(8'h08, 32'hF, 4'hF, 0, 0);

        // Read response held under RREADY low while a write proceeds on the other channel.
        write_check(8'h04, 32'h3F, 4'hF, 0, 0);
        @(negedge aclk);
        s_araddr = 8'h04;
        s_arvalid = 1;
        #1;
        checkOutput("bp_arready_pre", {31'd0, s_arready}, 32'd1);
        @(negedge aclk);
        s_arvalid = 0;
        write_check(8'h14, 32'hCAFE_0001, 4'hF, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            checkOutput("bp_rvalid", {31'd0, s_rvalid}, 32'd1);
            checkOutput("bp_rdata", s_rdata, 32'h3F);
            checkOutput("bp_arready", {31'd0, s_arready}, 32'd0);
        end
        s_rready = 1;
        @(negedge aclk);
        s_rready = 0;
        checkOutput("bp_released", {31'd0, s_rvalid}, 32'd0);
        read_check("bp_concurrent_write", 8'h14);

        axi_read(8'hFC, d, r);
        checkOutput("unmapped_rdata", d, 32'd0);
        checkOutput("unmapped_rresp", {30'd0, r}, {30'd0, UNMAP_RESP});
        write_check(8'hF0, 32'hFFFF_FFFF, 4'hF, 0, 0);
        read_check("unmapped_after_write", 8'hF0);

        // Reset in the middle of an outstanding read and an accepted write.
        @(negedge aclk);
        s_araddr = 8'h00; s_arvalid = 1;
        s_awaddr = 8'h04; s_awvalid = 1; s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1;
        @(negedge aclk);
        s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
        do_reset(2);
        #1;
        checkOutput("midrst_rvalid", {31'd0, s_rvalid}, 32'd0);
        checkOutput("midrst_bvalid", {31'd0, s_bvalid}, 32'd0);
        checkOutput("midrst_arready", {31'd0, s_arready}, 32'd1);
        checkOutput("midrst_seg", {24'd0, seg_out}, 32'd0);
        read_check("midrst_scratch0", 8'h10);

        applyStimulus(250);
        for (int a = 0; a < 8; a++) read_check("final_sweep", 8'(a << 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
